// File: rtl/gemips_mem_defs_pkg.sv
// Shared definitions for the MEM-stage SRAM sequencer.
//   - FSM state encodings
//   - byte-lane constants and SRAM idle pin values
//   - latched request payload
package gemips_mem_defs_pkg;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LANES  = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_e;

    // Active-low byte enables
    localparam logic [LANES-1:0] BE_N_NONE = 4'hF;
    localparam logic [LANES-1:0] BE_N_ALL  = 4'h0;

    // Deasserted level for ce_n / oe_n / we_n
    localparam logic PIN_OFF = 1'b1;

    // Request attributes held for the duration of one access
    typedef struct packed {
        logic       rd;
        logic       byte_op;
        logic [1:0] addr_lo;
    } mem_req_t;

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering for SRAM accesses (purely combinational).
//   addr_lo, byte_op   : lane select and access size
//   sram_rdata, wdata  : raw SRAM read word and store data
//   be_n_c             : active-low byte enables
//   load_data_c        : formatted load result (LB sign-extended)
//   store_data_c       : store data (SB replicated across lanes)
module mem_byte_lane
    import gemips_mem_defs_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  logic              byte_op,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic [DATA_W-1:0] wdata,
    output logic [LANES-1:0]  be_n_c,
    output logic [DATA_W-1:0] load_data_c,
    output logic [DATA_W-1:0] store_data_c
);

    logic [7:0] lane_byte;

    assign lane_byte = sram_rdata[{addr_lo, 3'b000} +: 8];

    // Word accesses pass through; byte accesses select/replicate one lane
    always_comb begin
        be_n_c       = BE_N_ALL;
        load_data_c  = sram_rdata;
        store_data_c = wdata;
        if (byte_op) begin
            be_n_c       = ~(LANES'(1) << addr_lo);
            load_data_c  = {{24{lane_byte[7]}}, lane_byte};
            store_data_c = {LANES{wdata[7:0]}};
        end
    end

endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage load/store sequencer for the external base SRAM.
//   mem_rd_req/mem_wr_req/mem_byte/mem_addr/mem_wdata : request from MEM (level)
//   mem_rdata     : load result, held until the next read capture
//   mem_stop_end  : one-cycle pulse when an access completes
//   busy          : high while the sequencer is not idle
//   sram_*        : registered SRAM pins (active-low strobes)
module mem_sram_ctrl
    import gemips_mem_defs_pkg::*;
#(
    parameter int unsigned SRAM_WAIT = 2,
    parameter int unsigned ADDR_W    = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd_req,
    input  logic              mem_wr_req,
    input  logic              mem_byte,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_stop_end,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mem_req_t          req_q, req_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [31:0]       sram_wdata_q, sram_wdata_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic [3:0]        be_n_q, be_n_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              stop_end_q, stop_end_d;
    logic              busy_q, busy_d;
    logic              in_access;

    logic [1:0]        lane_addr_lo;
    logic              lane_byte_op;
    logic [3:0]        lane_be_n;
    logic [31:0]       lane_load;
    logic [31:0]       lane_store;

    // Address bits above the SRAM window are discarded
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[31:ADDR_W+2];

    // Lane steering sees the incoming request in IDLE, the latched one afterwards
    assign lane_addr_lo = (state_q == ST_IDLE) ? mem_addr[1:0] : req_q.addr_lo;
    assign lane_byte_op = (state_q == ST_IDLE) ? mem_byte      : req_q.byte_op;

    mem_byte_lane u_byte_lane (
        .addr_lo      (lane_addr_lo),
        .byte_op      (lane_byte_op),
        .sram_rdata   (sram_rdata),
        .wdata        (mem_wdata),
        .be_n_c       (lane_be_n),
        .load_data_c  (lane_load),
        .store_data_c (lane_store)
    );

    // Next state, request latch and next pin values (pins reflect the state being entered)
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        mem_rdata_d  = mem_rdata_q;
        be_n_d       = be_n_q;

        unique case (state_q)
            ST_IDLE: begin
                if (mem_rd_req || mem_wr_req) begin
                    state_d       = ST_ACCESS;
                    cnt_d         = CNT_W'(SRAM_WAIT);
                    req_d.rd      = mem_rd_req;   // read wins if both are raised
                    req_d.byte_op = mem_byte;
                    req_d.addr_lo = mem_addr[1:0];
                    sram_addr_d   = mem_addr[ADDR_W+1:2];
                    sram_wdata_d  = lane_store;
                    be_n_d        = lane_be_n;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    if (req_q.rd) begin
                        mem_rdata_d = lane_load;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                // A request still high here is the stalled instruction itself
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_access = (state_d == ST_ACCESS);
        ce_n_d    = ~in_access;
        oe_n_d    = ~(in_access && req_d.rd);
        // we_n released on the last ACCESS cycle so data is held past the strobe
        we_n_d    = ~(in_access && !req_d.rd && (cnt_d != '0));
        if (!in_access) begin
            be_n_d = BE_N_NONE;
        end
        stop_end_d = (state_d == ST_DONE);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            mem_rdata_q  <= '0;
            be_n_q       <= BE_N_NONE;
            ce_n_q       <= PIN_OFF;
            oe_n_q       <= PIN_OFF;
            we_n_q       <= PIN_OFF;
            stop_end_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            mem_rdata_q  <= mem_rdata_d;
            be_n_q       <= be_n_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            stop_end_q   <= stop_end_d;
            busy_q       <= busy_d;
        end
    end

    assign mem_rdata    = mem_rdata_q;
    assign mem_stop_end = stop_end_q;
    assign busy         = busy_q;
    assign sram_addr    = sram_addr_q;
    assign sram_wdata   = sram_wdata_q;
    assign sram_ce_n    = ce_n_q;
    assign sram_oe_n    = oe_n_q;
    assign sram_we_n    = we_n_q;
    assign sram_be_n    = be_n_q;

endmodule
